// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back path.
// Used by the arbiter top and the pending-destination scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_0    = 2'b01,
    GNT_1    = 2'b10
  } gnt_e;

  function automatic logic is_zero(
    input logic [REG_ADDR_W-1:0] a
  );
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-destination scoreboard: one bit per register, r0 never set.
// Set on accepted issue, cleared when the write reaches the register file.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] chk_addr_1,
  input  logic [ADDR_W-1:0] chk_addr_2,
  output logic              hazard_1,
  output logic              hazard_2,
  output logic              set_busy
);

  localparam int N = 1 << ADDR_W;

  logic [N-1:0] pending;
  logic [N-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) pending <= '0;
    else pending <= pending_nxt;
  end

  assign hazard_1 = pending[chk_addr_1];
  assign hazard_2 = pending[chk_addr_2];
  assign set_busy = pending[set_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + output stage for the register file write port.
// Define RR_ARB_EN for round-robin arbitration (default: req0 priority).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] chk_addr_1,
  input  logic [ADDR_W-1:0] chk_addr_2,
  output logic              hazard_1,
  output logic              hazard_2,
  input  logic              flush,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data
);

  wb_req_t req0;
  wb_req_t req1;
  wb_req_t sel;
  gnt_e    gnt;
  logic    open;
  logic    conflict_to_1;
  logic    set_busy;
  logic    iss_fire;

  assign req0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
  assign req1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};

  assign open = rst_n && !flush;

`ifdef RR_ARB_EN
  // Holds the requester that wins the next conflict.
  logic rr_pref;

  always_ff @(posedge clk) begin
    if (!rst_n) rr_pref <= 1'b0;
    else if (gnt != GNT_NONE) rr_pref <= (gnt == GNT_0);
  end

  assign conflict_to_1 = rr_pref;
`else
  assign conflict_to_1 = 1'b0;
`endif

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      (!open || (!req0.valid && !req1.valid)):
        gnt = GNT_NONE;
      (open && req0.valid && !req1.valid):
        gnt = GNT_0;
      (open && !req0.valid && req1.valid):
        gnt = GNT_1;
      (open && req0.valid && req1.valid):
        gnt = conflict_to_1 ? GNT_1 : GNT_0;
      default:
        gnt = GNT_NONE;
    endcase
  end

  assign req0_ready = (gnt == GNT_0);
  assign req1_ready = (gnt == GNT_1);

  always_comb begin
    sel = '0;
    unique case (gnt)
      GNT_0:   sel = req0;
      GNT_1:   sel = req1;
      default: sel = '0;
    endcase
  end

  // write_data holds on idle cycles; only write_addr signals a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_addr <= REG_ZERO;
      write_data <= '0;
    end else begin
      write_addr <= sel.valid ? sel.addr : REG_ZERO;
      if (sel.valid) write_data <= sel.data;
    end
  end

  assign iss_ready = open && (is_zero(iss_dest) || !set_busy);
  assign iss_fire  = iss_valid && iss_ready && !is_zero(iss_dest);

  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .set_en     (iss_fire),
    .set_addr   (iss_dest),
    .clr_addr   (write_addr),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .hazard_1   (hazard_1),
    .hazard_2   (hazard_2),
    .set_busy   (set_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed cases, then random
// issue/write-back traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_dest = '0;
  logic        iss_ready;
  logic [4:0]  chk_addr_1 = '0, chk_addr_2 = '0;
  logic        hazard_1, hazard_2;
  logic        flush = 1'b0;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .iss_valid  (iss_valid),
    .iss_dest   (iss_dest),
    .iss_ready  (iss_ready),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .hazard_1   (hazard_1),
    .hazard_2   (hazard_2),
    .flush      (flush),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int failures = 0;

  wr_t expq[$];
  wr_t q0[$];
  wr_t q1[$];
  logic [4:0] outst[$];

  // Reference state: which registers await write-back, what the
  // register-file port shows, and who wins the next conflict.
  bit          pend[32];
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  int          m_pref = 0;
  int          last_gnt = -1;
  wr_t         mon_e;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (expq.size() != 0) begin
      mon_e = expq.pop_front();
      chk("write_addr", 32'(write_addr), 32'(mon_e.addr));
      chk("write_data", write_data, mon_e.data);
    end
  end

  // Called at a falling edge with control inputs set; returns at the next one.
  task automatic step();
    int  g;
    bit  iss_ok;
    wr_t w;
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (req0_valid) begin
      req0_addr = q0[0].addr;
      req0_data = q0[0].data;
    end
    if (req1_valid) begin
      req1_addr = q1[0].addr;
      req1_data = q1[0].data;
    end
    #1;
    g = -1;
    if (rst_n && !flush) begin
      if (req0_valid && req1_valid) g = m_pref;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    iss_ok = rst_n && !flush && (iss_dest == 0 || !pend[iss_dest]);
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("iss_ready", 32'(iss_ready), 32'(iss_ok));
    chk("hazard_1", 32'(hazard_1), 32'(chk_addr_1 != 0 && pend[chk_addr_1]));
    chk("hazard_2", 32'(hazard_2), 32'(chk_addr_2 != 0 && pend[chk_addr_2]));
    checks++;
    if (iss_valid && iss_ready && iss_dest != 0 && iss_dest == write_addr) begin
      failures++;
      $display("FAIL set_clear_same_reg actual=%0d required=none", iss_dest);
    end
    if (!rst_n) begin
      pend = '{default: 0};
      m_wa = '0;
      m_wd = '0;
      m_pref = 0;
    end else if (flush) begin
      pend = '{default: 0};
      m_wa = '0;
    end else begin
      if (m_wa != 0) pend[m_wa] = 0;
      if (iss_valid && iss_ok && iss_dest != 0) begin
        pend[iss_dest] = 1;
        outst.push_back(iss_dest);
      end
      if (g >= 0) begin
        w = (g == 0) ? q0[0] : q1[0];
        m_wa = w.addr;
        m_wd = w.data;
`ifdef RR_ARB_EN
        m_pref = 1 - g;
`endif
      end else begin
        m_wa = '0;
      end
    end
    last_gnt = g;
    if (g == 0) void'(q0.pop_front());
    if (g == 1) void'(q1.pop_front());
    expq.push_back('{m_wa, m_wd});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    iss_valid = 1'b0;
    flush = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    q0.delete();
    q1.delete();
    outst.delete();
  endtask

  int grants[4];
  int exp_g[4];
  int idx;

  initial begin
    @(negedge clk);
    do_reset();
    step();
    chk("idle_iss_ready", 32'(iss_ready), 32'd1);

    // Issue r5, write it back three edges later.
    chk_addr_1 = 5'd5;
    iss_valid = 1'b1;
    iss_dest = 5'd5;
    step();
    iss_valid = 1'b0;
    step();
    step();
    q0.push_back('{5'd5, 32'hDEADBEEF});
    step();
    chk("r5_hazard_before_commit", 32'(hazard_1), 32'd1);
    step();
    step();
    chk("r5_hazard_after_commit", 32'(hazard_1), 32'd0);

    // Back-to-back issue of r7 blocks until it retires.
    iss_valid = 1'b1;
    iss_dest = 5'd7;
    step();
    step();
    chk("r7_second_blocked", 32'(iss_ready), 32'd0);
    step();
    q1.push_back('{5'd7, 32'h0000_7777});
    for (int k = 0; k < 4; k++) step();
    iss_valid = 1'b0;

    // Both requesters contending.
    do_reset();
    iss_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iss_dest = 5'(k + 1);
      step();
      iss_dest = 5'(k + 10);
      step();
    end
    iss_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q0.push_back('{5'(k + 1), $urandom});
      q1.push_back('{5'(k + 10), $urandom});
    end
`ifdef RR_ARB_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      grants[k] = last_gnt;
    end
    for (int k = 0; k < 4; k++) chk("conflict_grant", 32'(grants[k]), 32'(exp_g[k]));
    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) step();
    chk("drain_q", 32'(q0.size() + q1.size()), 32'd0);
    step();

    // Write to r0 is accepted and dropped.
    q1.push_back('{5'd0, 32'h0000_1234});
    step();
    chk("r0_req_accepted", 32'(q1.size()), 32'd0);
    step();

    // flush, then reset, with r3/r9 pending and a transfer in flight.
    for (int pass = 0; pass < 2; pass++) begin
      chk_addr_1 = 5'd3;
      chk_addr_2 = 5'd9;
      iss_valid = 1'b1;
      iss_dest = 5'd3;
      step();
      iss_dest = 5'd9;
      step();
      iss_valid = 1'b0;
      q0.push_back('{5'd3, 32'hCAFE_0003});
      step();
      if (pass == 0) flush = 1'b1;
      else rst_n = 1'b0;
      step();
      flush = 1'b0;
      rst_n = 1'b1;
      step();
      chk("clear_hazard_r9", 32'(hazard_2), 32'd0);
      chk("clear_write_addr", 32'(write_addr), 32'd0);
      q0.delete();
      q1.delete();
    end

    // Random traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_dest = 5'($urandom_range(0, 31));
      chk_addr_1 = 5'($urandom_range(0, 31));
      chk_addr_2 = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 60) == 0);
      if (q0.size() == 0 && outst.size() != 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, outst.size() - 1);
        q0.push_back('{outst[idx], $urandom});
        outst.delete(idx);
      end
      if (q1.size() == 0 && $urandom_range(0, 2) != 0) begin
        if (outst.size() != 0 && $urandom_range(0, 7) != 0) begin
          idx = $urandom_range(0, outst.size() - 1);
          q1.push_back('{outst[idx], $urandom});
          outst.delete(idx);
        end else if ($urandom_range(0, 5) == 0) begin
          q1.push_back('{5'd0, $urandom});
        end
      end
      step();
      if (flush) begin
        q0.delete();
        q1.delete();
        outst.delete();
      end
    end
    flush = 1'b0;
    iss_valid = 1'b0;
    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) step();
    step();
    step();
    @(posedge clk);
    #2;
    chk("expq_empty", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
